// File: rtl/rgb_yuv_encoder.sv
// rgb_yuv_encoder
//   Reads a packed RGB image from SRAM, converts it to Y/U/V and writes
//   separate Y, U and V planes back to SRAM, one 4-pixel group per 18-cycle
//   pass. Chroma is horizontally subsampled by two.
//
//   Ports
//     Clock            sole clock, rising edge
//     Resetn           synchronous active-low reset
//     Enable           start request, only looked at while idle
//     SRAM_address     SRAM word address (registered)
//     SRAM_read_data   SRAM read word, valid two cycles after its address
//     SRAM_write_data  SRAM write word (registered)
//     SRAM_we_n        active-low write enable (registered)
//     Done             one-cycle pulse after the last group is written
//
//   Build option
//     RGB_ENC_CHROMA_AVG_EN  defined: chroma for pixel 2j is the rounded
//                            average of pixels 2j and 2j+1.
//                            undefined: chroma uses pixel 2j directly.
//
//   Scheduling: three shared multipliers compute one Y/U/V value per cycle.
//   The first chroma pair (pixel 4k) is evaluated in S_LAT0/S_LAT1, where the
//   multipliers would otherwise sit idle and that pixel's words have already
//   arrived; the second pair (pixel 4k+2) completes the U word in S_C4 and
//   the V word in S_C5.
module rgb_yuv_encoder #(
   parameter logic [17:0] RGB_BASE   = 18'd146944,
   parameter logic [17:0] Y_BASE     = 18'd0,
   parameter logic [17:0] U_BASE     = 18'd38400,
   parameter logic [17:0] V_BASE     = 18'd57600,
   parameter int          NUM_GROUPS = 19200
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Enable,
   output logic [17:0] SRAM_address,
   input  logic [15:0] SRAM_read_data,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   output logic        Done
);

   typedef enum logic [4:0] {
      S_IDLE,
      S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5,
      S_LAT0, S_LAT1,
      S_C0, S_C1, S_C2, S_C3, S_C4, S_C5,
      S_WY01, S_WY23, S_WU, S_WV
   } state_t;

   typedef enum logic [1:0] {CF_NONE, CF_Y, CF_U, CF_V} coef_t;

   localparam logic [17:0] LAST_K = 18'(NUM_GROUPS - 1);

   state_t      state;
   logic [17:0] k;

   logic [15:0] rgb_word [0:5];
   logic [7:0]  px_r [0:3];
   logic [7:0]  px_g [0:3];
   logic [7:0]  px_b [0:3];
   logic [7:0]  ca_r, ca_g, ca_b;   // chroma source for pixel 4k
   logic [7:0]  cb_r, cb_g, cb_b;   // chroma source for pixel 4k+2

   logic [7:0]  y_pix [0:3];
   logic [7:0]  u_a, v_a, u_b, v_b;

   logic [7:0]         sel_r, sel_g, sel_b;
   coef_t              csel;
   logic signed [31:0] c_r, c_g, c_b, offset;
   logic signed [31:0] sum, scaled;
   logic [7:0]         conv_out;

   // Unpack the six words: {R0,G0} {B0,R1} {G1,B1} {R2,G2} {B2,R3} {G3,B3}
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         px_r[2*p]   = rgb_word[3*p][15:8];
         px_g[2*p]   = rgb_word[3*p][7:0];
         px_b[2*p]   = rgb_word[3*p+1][15:8];
         px_r[2*p+1] = rgb_word[3*p+1][7:0];
         px_g[2*p+1] = rgb_word[3*p+2][15:8];
         px_b[2*p+1] = rgb_word[3*p+2][7:0];
      end
   end

`ifdef RGB_ENC_CHROMA_AVG_EN
   function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b} + 9'd1;
      return s[8:1];
   endfunction

   assign ca_r = avg2(px_r[0], px_r[1]);
   assign ca_g = avg2(px_g[0], px_g[1]);
   assign ca_b = avg2(px_b[0], px_b[1]);
   assign cb_r = avg2(px_r[2], px_r[3]);
   assign cb_g = avg2(px_g[2], px_g[3]);
   assign cb_b = avg2(px_b[2], px_b[3]);
`else
   assign ca_r = px_r[0];
   assign ca_g = px_g[0];
   assign ca_b = px_b[0];
   assign cb_r = px_r[2];
   assign cb_g = px_g[2];
   assign cb_b = px_b[2];
`endif

   // Shared conversion datapath: operand/coefficient select, 3 multipliers, clip.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      sel_r  = '0;
      sel_g  = '0;
      sel_b  = '0;
      csel   = CF_NONE;
      c_r    = '0;
      c_g    = '0;
      c_b    = '0;
      offset = '0;
      case (state)
         S_LAT0: begin sel_r = ca_r;     sel_g = ca_g;     sel_b = ca_b;     csel = CF_U; end
         S_LAT1: begin sel_r = ca_r;     sel_g = ca_g;     sel_b = ca_b;     csel = CF_V; end
         S_C0:   begin sel_r = px_r[0];  sel_g = px_g[0];  sel_b = px_b[0];  csel = CF_Y; end
         S_C1:   begin sel_r = px_r[1];  sel_g = px_g[1];  sel_b = px_b[1];  csel = CF_Y; end
         S_C2:   begin sel_r = px_r[2];  sel_g = px_g[2];  sel_b = px_b[2];  csel = CF_Y; end
         S_C3:   begin sel_r = px_r[3];  sel_g = px_g[3];  sel_b = px_b[3];  csel = CF_Y; end
         S_C4:   begin sel_r = cb_r;     sel_g = cb_g;     sel_b = cb_b;     csel = CF_U; end
         S_C5:   begin sel_r = cb_r;     sel_g = cb_g;     sel_b = cb_b;     csel = CF_V; end
         default: ;
      endcase
      case (csel)
         CF_Y: begin c_r = 32'sd16843;  c_g = 32'sd33030;  c_b = 32'sd6423;   offset = 32'sd16;  end
         CF_U: begin c_r = -32'sd9699;  c_g = -32'sd19071; c_b = 32'sd28770;  offset = 32'sd128; end
         CF_V: begin c_r = 32'sd28770;  c_g = -32'sd24117; c_b = -32'sd4653;  offset = 32'sd128; end
         default: ;
      endcase
      sum = c_r * $signed({24'd0, sel_r}) + c_g * $signed({24'd0, sel_g})
          + c_b * $signed({24'd0, sel_b}) + 32'sd32768;
      scaled = (sum >>> 16) + offset;
      if (scaled < 32'sd0)
         conv_out = 8'd0;
      else if (scaled > 32'sd255)
         conv_out = 8'd255;
      else
         conv_out = scaled[7:0];
   end

   // Read capture and result registers. Each word arrives two states after
   // its address, so words 0..5 land in S_RD2..S_LAT1.
   // NOTE: pure datapath registers carry no reset; the FSM never consumes
   // them before they have been loaded in the current pass.
   always_ff @(posedge Clock) begin
      case (state)
         S_RD2:  rgb_word[0] <= SRAM_read_data;
         S_RD3:  rgb_word[1] <= SRAM_read_data;
         S_RD4:  rgb_word[2] <= SRAM_read_data;
         S_RD5:  rgb_word[3] <= SRAM_read_data;
         S_LAT0: begin rgb_word[4] <= SRAM_read_data; u_a <= conv_out; end
         S_LAT1: begin rgb_word[5] <= SRAM_read_data; v_a <= conv_out; end
         S_C0:   y_pix[0] <= conv_out;
         S_C1:   y_pix[1] <= conv_out;
         S_C2:   y_pix[2] <= conv_out;
         S_C3:   y_pix[3] <= conv_out;
         S_C4:   u_b <= conv_out;
         S_C5:   v_b <= conv_out;
         default: ;
      endcase
   end

   // Control FSM with registered SRAM outputs: the values set on a transition
   // are what the SRAM sees during the state being entered.
   always_ff @(posedge Clock) begin
      // NOTE: reset is sampled on the clock edge only; there is no async path.
      if (!Resetn) begin
         state           <= S_IDLE;
         k               <= '0;
         SRAM_address    <= '0;
         SRAM_write_data <= '0;
         SRAM_we_n       <= 1'b1;
         Done            <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            S_IDLE: if (Enable) begin
               k            <= '0;
               SRAM_address <= RGB_BASE;
               SRAM_we_n    <= 1'b1;
               state        <= S_RD0;
            end
            S_RD0: begin SRAM_address <= SRAM_address + 18'd1; state <= S_RD1; end
            S_RD1: begin SRAM_address <= SRAM_address + 18'd1; state <= S_RD2; end
            S_RD2: begin SRAM_address <= SRAM_address + 18'd1; state <= S_RD3; end
            S_RD3: begin SRAM_address <= SRAM_address + 18'd1; state <= S_RD4; end
            S_RD4: begin SRAM_address <= SRAM_address + 18'd1; state <= S_RD5; end
            S_RD5:  state <= S_LAT0;
            S_LAT0: state <= S_LAT1;
            S_LAT1: state <= S_C0;
            S_C0:   state <= S_C1;
            S_C1:   state <= S_C2;
            S_C2:   state <= S_C3;
            S_C3:   state <= S_C4;
            S_C4:   state <= S_C5;
            S_C5: begin
               SRAM_address    <= Y_BASE + {k[16:0], 1'b0};
               SRAM_write_data <= {y_pix[0], y_pix[1]};
               SRAM_we_n       <= 1'b0;
               state           <= S_WY01;
            end
            S_WY01: begin
               SRAM_address    <= Y_BASE + {k[16:0], 1'b0} + 18'd1;
               SRAM_write_data <= {y_pix[2], y_pix[3]};
               state           <= S_WY23;
            end
            S_WY23: begin
               SRAM_address    <= U_BASE + k;
               SRAM_write_data <= {u_a, u_b};
               state           <= S_WU;
            end
            S_WU: begin
               SRAM_address    <= V_BASE + k;
               SRAM_write_data <= {v_a, v_b};
               state           <= S_WV;
            end
            S_WV: begin
               SRAM_we_n <= 1'b1;
               if (k == LAST_K) begin
                  Done  <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  k            <= k + 18'd1;
                  SRAM_address <= RGB_BASE + 18'd6 * (k + 18'd1);
                  state        <= S_RD0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
